lsb_extractor: RTL and testbench
================================

LSB_EXTRACTOR -- requirements
Module: lsb_extractor

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 8, width of one input pixel sample.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of each byte pushed to the downstream FIFO.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the embedded message-length header (in bytes).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin one extraction.
REQ-008 pix_valid  input  1  pix_data is valid this cycle.
REQ-009 pix_data  input  PIX_WIDTH  stego pixel sample; only bit 0 is used.
REQ-010 pix_ready  output  1  block accepts pix_data this cycle.
REQ-011 wren  output  1  FIFO write strobe.
REQ-012 din  output  DATA_WIDTH  byte presented to the FIFO.
REQ-013 full  input  1  FIFO full flag.
REQ-014 busy  output  1  extraction in progress.
REQ-015 done  output  1  one-cycle pulse when extraction completes.
REQ-016 msg_len  output  LEN_WIDTH  decoded length header.

Function
REQ-017 A pixel SHALL be accepted only on a cycle where pix_valid and pix_ready are both 1; bits [PIX_WIDTH-1:1] SHALL be ignored.
REQ-018 The state machine SHALL have exactly four states: IDLE, LEN, DATA and DONE.
REQ-019 IDLE: pix_ready=0 and busy=0; start=1 SHALL move to LEN and clear the bit and byte counters; start SHALL be ignored in every other state.
REQ-020 LEN: pix_ready=1; each accepted pixel LSB SHALL shift into the length register MSB-first; after LEN_WIDTH accepts, msg_len SHALL update.
REQ-021 LEN exit: if the decoded length is 0, SHALL go to DONE; otherwise SHALL go to DATA with remaining=length.
REQ-022 DATA: LSBs SHALL shift MSB-first into a byte register; on the DATA_WIDTH-th accept, the byte SHALL load into din and set an internal pend flag on the next edge.
REQ-023 wren SHALL equal pend AND NOT full; a push occurs on each cycle with wren=1, clearing pend and decrementing remaining.
REQ-024 In DATA, pix_ready SHALL equal (NOT pend) OR (NOT full); a pixel may be accepted in the same cycle as a push.
REQ-025 While pend=1 and full=1, din SHALL stay stable and no pixel SHALL be accepted.
REQ-026 When the push of the last byte occurs (remaining reaches 0), the block SHALL go to DONE on that edge; pix_ready SHALL be 0 once the final bit has been accepted.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE; busy SHALL be 1 only in LEN and DATA.
REQ-028 msg_len SHALL hold its last value until the next LEN completes.
REQ-029 The block SHALL never assert wren more than once per byte, nor when full=1.
REQ-030 Latency: wren SHALL first be able to assert one cycle after the edge that accepted the final bit of a byte.

Reset
REQ-031 Asserting rst at any time SHALL immediately force IDLE and set pix_ready=0, wren=0, din=0, busy=0, done=0 and msg_len=0.
REQ-032 On reset, the counters, shift registers and pend SHALL clear; a byte pending at reset SHALL be discarded and not written.
REQ-033 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-034 Header LSBs 0x0002, then data LSBs encoding 0x53 and 0x4B, pix_valid=1 continuously, full=0 -> exactly two wren pulses with din=0x53 then 0x4B; msg_len=2; done pulses the cycle after the second push.
REQ-035 Header 0x0000 -> no wren; done=1 one cycle after the 16th accepted pixel.
REQ-036 full=1 for 5 cycles while pend=1 -> wren=0, din stable, pix_ready=0 for those 5 cycles; a single push occurs on the first cycle with full=0.
REQ-037 pix_valid toggled randomly and pixels 0xFE/0x01 with identical LSB pattern -> identical byte sequence; upper bits have no effect.
REQ-038 start pulsed mid-DATA -> ignored, stream unaffected; rst asserted mid-DATA with pend=1 -> all outputs 0 at once, no wren, and a later start runs a clean extraction.

Source files
------------

// File: rtl/lsb_extractor_if.sv
// Pixel-in / byte-out handshake bundle for the LSB extractor.
// slave is the extractor's view; master is the view of whoever drives
// pixels, owns the FIFO and reads back status.
interface lsb_extractor_if #(
   parameter int PIX_WIDTH  = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
);
   logic                  start;
   logic                  pix_valid;
   logic [PIX_WIDTH-1:0]  pix_data;
   logic                  pix_ready;
   logic                  wren;
   logic [DATA_WIDTH-1:0] din;
   logic                  full;
   logic                  busy;
   logic                  done;
   logic [LEN_WIDTH-1:0]  msg_len;

   modport master (
      output start, pix_valid, pix_data, full,
      input  pix_ready, wren, din, busy, done, msg_len
   );

   modport slave (
      input  start, pix_valid, pix_data, full,
      output pix_ready, wren, din, busy, done, msg_len
   );
endinterface

// File: rtl/lsb_extractor.sv
// Recovers a length-prefixed byte message hidden in pixel LSBs and pushes
// the bytes into a downstream FIFO.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; no pixels taken
// LEN    | shifting LEN_WIDTH pixel LSBs MSB-first into the length header
// DATA   | shifting payload bytes; each full byte is held (pend) until
//        | the FIFO has room, then pushed
// DONE   | one-cycle done pulse, then back to IDLE
module lsb_extractor #(
   parameter int PIX_WIDTH  = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input logic            clk,
   input logic            rst,
   lsb_extractor_if.slave bus
);

   localparam int CNT_MAX = (LEN_WIDTH > DATA_WIDTH) ? LEN_WIDTH : DATA_WIDTH;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] LEN_LOAD  = CNT_W'(LEN_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_DONE
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [CNT_W-1:0]      bit_cnt;
   logic [LEN_WIDTH-2:0]  len_sr;
   logic [DATA_WIDTH-2:0] byte_sr;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [LEN_WIDTH-1:0]  recv_left;
   logic [LEN_WIDTH-1:0]  msg_len_q;
   logic [DATA_WIDTH-1:0] din_q;
   logic                  pend;

   logic [PIX_WIDTH-1:0]  pix_word;
   logic                  pix_lsb;
   logic                  pix_ready;
   logic                  wren;
   logic                  busy;
   logic                  done;
   logic                  accept;
   logic                  bit_tc;
   logic                  byte_done;
   logic [LEN_WIDTH-1:0]  len_word;
   logic [DATA_WIDTH-1:0] byte_word;

   // Mask to bit 0 so every upper pixel bit is an explicit don't-care.
   assign pix_word  = bus.pix_data;
   assign pix_lsb   = |(pix_word & PIX_WIDTH'(1));

   assign bit_tc    = (bit_cnt == '0);
   assign len_word  = {len_sr, pix_lsb};
   assign byte_word = {byte_sr, pix_lsb};

   // A held byte blocks new pixels only while the FIFO is full; once the
   // last payload byte has been collected no further pixels are taken.
   assign wren      = (state == S_DATA) && pend && !bus.full;
   assign pix_ready = (state == S_LEN) ||
                      ((state == S_DATA) && (recv_left != '0) && (!pend || !bus.full));
   assign accept    = bus.pix_valid && pix_ready;
   assign byte_done = (state == S_DATA) && accept && bit_tc;

   assign bus.pix_ready = pix_ready;
   assign bus.wren      = wren;
   assign bus.din       = din_q;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.msg_len   = msg_len_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = S_LEN;
         end
         S_LEN: begin
            busy = 1'b1;
            if (accept && bit_tc) begin
               state_nxt = (len_word == '0) ? S_DONE : S_DATA;
            end
         end
         S_DATA: begin
            busy = 1'b1;
            if (wren && (remaining == LEN_WIDTH'(1))) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bit/byte counters, shift registers, the held output byte and pend.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         len_sr    <= '0;
         byte_sr   <= '0;
         remaining <= '0;
         recv_left <= '0;
         msg_len_q <= '0;
         din_q     <= '0;
         pend      <= 1'b0;
      end else begin
         if ((state == S_IDLE) && bus.start) begin
            bit_cnt   <= LEN_LOAD;
            len_sr    <= '0;
            byte_sr   <= '0;
            remaining <= '0;
            recv_left <= '0;
            pend      <= 1'b0;
         end

         if ((state == S_LEN) && accept) begin
            len_sr <= len_word[LEN_WIDTH-2:0];
            if (bit_tc) begin
               msg_len_q <= len_word;
               remaining <= len_word;
               recv_left <= len_word;
               bit_cnt   <= DATA_LOAD;
            end else begin
               bit_cnt <= bit_cnt - CNT_W'(1);
            end
         end

         if ((state == S_DATA) && accept) begin
            byte_sr <= byte_word[DATA_WIDTH-2:0];
            if (bit_tc) begin
               din_q     <= byte_word;
               recv_left <= recv_left - LEN_WIDTH'(1);
               bit_cnt   <= DATA_LOAD;
            end else begin
               bit_cnt <= bit_cnt - CNT_W'(1);
            end
         end

         // A push and a newly completed byte on the same edge leave pend set.
         if (byte_done) begin
            pend <= 1'b1;
         end else if (wren) begin
            pend <= 1'b0;
         end

         if (wren) remaining <= remaining - LEN_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_lsb_extractor.sv
// Self-checking bench for lsb_extractor: messages are built as byte lists,
// serialised MSB-first into pixel LSBs behind a 16-bit length header, and
// the FIFO writes are compared against the original message.
module tb_lsb_extractor;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   lsb_extractor_if #(.PIX_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(16)) bus ();

   lsb_extractor #(.PIX_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mkpix(input bit b, input int mode);
      logic [7:0] r;
      r = 8'($urandom());
      case (mode)
         0:       return {7'b0, b};
         1:       return b ? 8'h01 : 8'hFE;
         default: return {r[7:1], b};
      endcase
   endfunction

   function automatic void build_bits(input logic [15:0] hdr, input logic [7:0] msg[$],
                                      output bit bits[$]);
      bits.delete();
      for (int i = 15; i >= 0; i--) bits.push_back(((hdr >> i) & 16'd1) != 16'd0);
      foreach (msg[k])
         for (int i = 7; i >= 0; i--) bits.push_back(((msg[k] >> i) & 8'd1) != 8'd0);
   endfunction

   // Full extraction: start pulse, then random-valid pixel stream and random
   // FIFO-full pattern; records writes and event cycles until done.
   task automatic run_stream(input logic [15:0] hdr, input logic [7:0] msg[$],
                             input int vpct, input int fpct, input int mode, input int start_at,
                             output logic [7:0] got[$], output int t_done, output int t_wren,
                             output int t_acc, output int viol, output bit tmo);
      bit bits[$];
      int idx;
      build_bits(hdr, msg, bits);
      got.delete();
      t_done = -1; t_wren = -1; t_acc = -1; viol = 0; tmo = 1'b1; idx = 0;
      @(posedge clk); #1 bus.start = 1'b1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(posedge clk); #1;
         bus.start     = (cyc == start_at);
         bus.pix_valid = (idx < bits.size()) && ($urandom_range(99) < vpct);
         bus.pix_data  = mkpix((idx < bits.size()) ? bits[idx] : 1'b0, mode);
         bus.full      = ($urandom_range(99) < fpct);
         @(negedge clk);
         if (bus.wren) begin
            got.push_back(bus.din);
            t_wren = cyc;
            if (bus.full) viol++;
         end
         if ((idx >= bits.size()) && bus.pix_ready) viol++;
         if (bus.pix_valid && bus.pix_ready) begin
            idx++;
            t_acc = cyc;
         end
         if (bus.done) begin
            t_done = cyc;
            tmo    = 1'b0;
            break;
         end
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.pix_valid = 1'b0; bus.full = 1'b0;
   endtask

   // Feed bits with full=0 until `upto` have been offered and seen ready;
   // returns at the negedge before the edge that takes the last one.
   task automatic feed_bits(input bit bits[$], inout int idx, input int upto, output bit tmo);
      tmo = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         bus.pix_valid = 1'b1;
         bus.pix_data  = mkpix(bits[idx], 2);
         bus.full      = 1'b0;
         @(negedge clk);
         if (bus.pix_ready) idx++;
         if (idx == upto) begin
            tmo = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0; bus.full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.pix_ready !== 1'b0) begin errors++; $display("FAIL rst_pix_ready got %b exp 0", bus.pix_ready); end
      checks++; if (bus.wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b exp 0", bus.wren); end
      checks++; if (bus.din !== 8'h00) begin errors++; $display("FAIL rst_din got %h exp 00", bus.din); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
      checks++; if (bus.msg_len !== 16'h0000) begin errors++; $display("FAIL rst_msg_len got %h exp 0000", bus.msg_len); end
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_wait_busy got %b exp 0", bus.busy); end
   endtask

   task automatic test_directed_sk();
      logic [7:0] msg[$];
      logic [7:0] got[$];
      int td, tw, ta, viol;
      bit tmo;
      msg = '{8'h53, 8'h4B};
      run_stream(16'd2, msg, 100, 0, 0, -1, got, td, tw, ta, viol, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL sk_timeout got %b exp 0", tmo); end
      checks++; if (got.size() !== 2) begin errors++; $display("FAIL sk_count got %0d exp 2", got.size()); end
      if (got.size() >= 2) begin
         checks++; if (got[0] !== 8'h53) begin errors++; $display("FAIL sk_byte0 got %h exp 53", got[0]); end
         checks++; if (got[1] !== 8'h4B) begin errors++; $display("FAIL sk_byte1 got %h exp 4B", got[1]); end
      end
      checks++; if (bus.msg_len !== 16'd2) begin errors++; $display("FAIL sk_msg_len got %0d exp 2", bus.msg_len); end
      checks++; if (td !== tw + 1) begin errors++; $display("FAIL sk_done_timing got %0d exp %0d", td, tw + 1); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL sk_violations got %0d exp 0", viol); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL sk_done_width got %b exp 0", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sk_busy_after got %b exp 0", bus.busy); end
   endtask

   task automatic test_zero_len();
      logic [7:0] msg[$];
      logic [7:0] got[$];
      int td, tw, ta, viol;
      bit tmo;
      msg.delete();
      run_stream(16'd0, msg, 100, 0, 2, -1, got, td, tw, ta, viol, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL zero_timeout got %b exp 0", tmo); end
      checks++; if (got.size() !== 0) begin errors++; $display("FAIL zero_wren_count got %0d exp 0", got.size()); end
      checks++; if (td !== ta + 1) begin errors++; $display("FAIL zero_done_timing got %0d exp %0d", td, ta + 1); end
      checks++; if (bus.msg_len !== 16'd0) begin errors++; $display("FAIL zero_msg_len got %0d exp 0", bus.msg_len); end
   endtask

   task automatic test_full_stall();
      logic [7:0] msg[$];
      logic [7:0] got[$];
      bit bits[$];
      int idx;
      bit tmo;
      bit seen_done;
      msg = '{8'($urandom()), 8'($urandom())};
      build_bits(16'd2, msg, bits);
      idx = 0;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      feed_bits(bits, idx, 24, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL stall_feed_timeout got %b exp 0", tmo); end
      for (int s = 0; s < 5; s++) begin
         @(posedge clk); #1;
         bus.full = 1'b1; bus.pix_valid = 1'b1; bus.pix_data = mkpix(bits[idx], 2);
         @(negedge clk);
         checks++; if (bus.wren !== 1'b0) begin errors++; $display("FAIL stall_wren c%0d got %b exp 0", s, bus.wren); end
         checks++; if (bus.pix_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d got %b exp 0", s, bus.pix_ready); end
         checks++; if (bus.din !== msg[0]) begin errors++; $display("FAIL stall_din c%0d got %h exp %h", s, bus.din, msg[0]); end
      end
      @(posedge clk); #1 bus.full = 1'b0;
      @(negedge clk);
      checks++; if (bus.wren !== 1'b1) begin errors++; $display("FAIL stall_release_wren got %b exp 1", bus.wren); end
      checks++; if (bus.din !== msg[0]) begin errors++; $display("FAIL stall_release_din got %h exp %h", bus.din, msg[0]); end
      checks++; if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", bus.pix_ready); end
      if (bus.pix_ready) idx++;
      got.delete();
      seen_done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         bus.pix_valid = (idx < bits.size());
         bus.pix_data  = mkpix((idx < bits.size()) ? bits[idx] : 1'b0, 2);
         @(negedge clk);
         if (bus.wren) got.push_back(bus.din);
         if (bus.pix_valid && bus.pix_ready) idx++;
         if (bus.done) begin
            seen_done = 1'b1;
            break;
         end
      end
      @(posedge clk); #1 bus.pix_valid = 1'b0;
      checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL stall_done_seen got %b exp 1", seen_done); end
      checks++; if (got.size() !== 1) begin errors++; $display("FAIL stall_remaining_pushes got %0d exp 1", got.size()); end
      if (got.size() >= 1) begin
         checks++; if (got[0] !== msg[1]) begin errors++; $display("FAIL stall_byte1 got %h exp %h", got[0], msg[1]); end
      end
   endtask

   task automatic test_random_streams();
      logic [7:0] msg[$];
      logic [7:0] got[$];
      int td, tw, ta, viol, len;
      bit tmo;
      for (int t = 0; t < 6; t++) begin
         len = $urandom_range(1, 5);
         msg.delete();
         for (int k = 0; k < len; k++) msg.push_back(8'($urandom()));
         run_stream(16'(len), msg, $urandom_range(40, 100), $urandom_range(0, 50), 2, -1,
                    got, td, tw, ta, viol, tmo);
         checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got %b exp 0", t, tmo); end
         checks++; if (got.size() !== len) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", t, got.size(), len); end
         for (int k = 0; k < len && k < got.size(); k++) begin
            checks++; if (got[k] !== msg[k]) begin errors++; $display("FAIL rnd%0d_byte%0d got %h exp %h", t, k, got[k], msg[k]); end
         end
         checks++; if (bus.msg_len !== 16'(len)) begin errors++; $display("FAIL rnd%0d_msg_len got %0d exp %0d", t, bus.msg_len, len); end
         checks++; if (td !== tw + 1) begin errors++; $display("FAIL rnd%0d_done_timing got %0d exp %0d", t, td, tw + 1); end
         checks++; if (viol !== 0) begin errors++; $display("FAIL rnd%0d_violations got %0d exp 0", t, viol); end
      end
   endtask

   task automatic test_upper_bits();
      logic [7:0] msg[$];
      logic [7:0] got[$];
      int td, tw, ta, viol;
      bit tmo;
      msg.delete();
      for (int k = 0; k < 4; k++) msg.push_back(8'($urandom()));
      for (int m = 0; m < 2; m++) begin
         run_stream(16'd4, msg, 60, 20, m, -1, got, td, tw, ta, viol, tmo);
         checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL upper_m%0d_timeout got %b exp 0", m, tmo); end
         checks++; if (got.size() !== 4) begin errors++; $display("FAIL upper_m%0d_count got %0d exp 4", m, got.size()); end
         for (int k = 0; k < 4 && k < got.size(); k++) begin
            checks++; if (got[k] !== msg[k]) begin errors++; $display("FAIL upper_m%0d_byte%0d got %h exp %h", m, k, got[k], msg[k]); end
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [7:0] msg[$];
      logic [7:0] got[$];
      int td, tw, ta, viol;
      bit tmo;
      msg = '{8'($urandom()), 8'($urandom()), 8'($urandom())};
      run_stream(16'd3, msg, 100, 0, 2, 25, got, td, tw, ta, viol, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL midstart_timeout got %b exp 0", tmo); end
      checks++; if (got.size() !== 3) begin errors++; $display("FAIL midstart_count got %0d exp 3", got.size()); end
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         checks++; if (got[k] !== msg[k]) begin errors++; $display("FAIL midstart_byte%0d got %h exp %h", k, got[k], msg[k]); end
      end
      checks++; if (bus.msg_len !== 16'd3) begin errors++; $display("FAIL midstart_msg_len got %0d exp 3", bus.msg_len); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] msg[$];
      logic [7:0] got[$];
      bit bits[$];
      int idx, td, tw, ta, viol;
      bit tmo;
      msg = '{8'($urandom()), 8'($urandom())};
      build_bits(16'd2, msg, bits);
      idx = 0;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      feed_bits(bits, idx, 24, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rstmid_feed_timeout got %b exp 0", tmo); end
      @(posedge clk); #1 bus.full = 1'b1; bus.pix_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %b exp 1", bus.busy); end
      checks++; if (bus.din !== msg[0]) begin errors++; $display("FAIL rstmid_pre_din got %h exp %h", bus.din, msg[0]); end
      @(posedge clk); #3 rst = 1'b1;
      #1;
      checks++; if (bus.pix_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pix_ready got %b exp 0", bus.pix_ready); end
      checks++; if (bus.wren !== 1'b0) begin errors++; $display("FAIL rstmid_wren got %b exp 0", bus.wren); end
      checks++; if (bus.din !== 8'h00) begin errors++; $display("FAIL rstmid_din got %h exp 00", bus.din); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
      checks++; if (bus.msg_len !== 16'h0000) begin errors++; $display("FAIL rstmid_msg_len got %h exp 0000", bus.msg_len); end
      bus.full = 1'b0;
      @(negedge clk);
      checks++; if (bus.wren !== 1'b0) begin errors++; $display("FAIL rstmid_hold_wren got %b exp 0", bus.wren); end
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus.wren !== 1'b0) begin errors++; $display("FAIL rstmid_post_wren c%0d got %b exp 0", c, bus.wren); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_post_busy c%0d got %b exp 0", c, bus.busy); end
      end
      msg = '{8'($urandom()), 8'($urandom())};
      run_stream(16'd2, msg, 80, 20, 2, -1, got, td, tw, ta, viol, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rstmid_clean_timeout got %b exp 0", tmo); end
      checks++; if (got.size() !== 2) begin errors++; $display("FAIL rstmid_clean_count got %0d exp 2", got.size()); end
      for (int k = 0; k < 2 && k < got.size(); k++) begin
         checks++; if (got[k] !== msg[k]) begin errors++; $display("FAIL rstmid_clean_byte%0d got %h exp %h", k, got[k], msg[k]); end
      end
      checks++; if (viol !== 0) begin errors++; $display("FAIL rstmid_clean_violations got %0d exp 0", viol); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_directed_sk();
      test_zero_len();
      test_full_stall();
      test_random_streams();
      test_upper_bits();
      test_start_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
